// File: rtl/vault_phase_sequencer.sv
// Master sequencer for the vault puzzle chain: runs each phase FSM in turn,
// tracks failed attempts and drives the alarm, lockout and vault-open outputs.
module vault_phase_sequencer #(
    parameter int NUM_PHASES     = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int PHASE_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  relock,
    input  logic [NUM_PHASES-1:0] phase_done,
    input  logic [NUM_PHASES-1:0] phase_fail,
    output logic [NUM_PHASES-1:0] phase_clr,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [2:0]            cur_phase,
    output logic [3:0]            attempts_left,
    output logic                  busy,
    output logic                  locked_out,
    output logic                  vault_open,
    output logic                  alarm
);

    localparam int              IDX_W     = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
    localparam logic [3:0]      ATT_INIT  = 4'(MAX_ATTEMPTS);
    localparam logic [15:0]     LOCK_INIT = 16'(LOCKOUT_CYCLES);
    localparam logic [15:0]     TMO_LAST  = 16'(PHASE_TIMEOUT - 1);
    localparam bit              TMO_EN    = (PHASE_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_LOCKOUT = 3'd3,
        S_OPEN    = 3'd4,
        S_ALARM   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              att_q, att_d;
    logic [15:0]             timer_q, timer_d;
    logic [15:0]             lock_q, lock_d;

    logic [NUM_PHASES-1:0]   clr_q, clr_d;
    logic [NUM_PHASES-1:0]   en_q, en_d;
    logic [2:0]              cur_q, cur_d;
    logic [3:0]              att_out_q;
    logic                    busy_q, busy_d;
    logic                    lockd_q, lockd_d;
    logic                    open_q, open_d;
    logic                    alarm_q, alarm_d;

    logic [NUM_PHASES-1:0]   sel_s;
    logic                    fail_act_s;
    logic                    done_act_s;
    logic                    timeout_s;
    logic                    fail_evt_s;
    logic [3:0]              att_dec_s;

    function automatic logic [NUM_PHASES-1:0] onehot_f(input logic [IDX_W-1:0] sel);
        logic [NUM_PHASES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            v[i] = (sel == IDX_W'(i));
        end
        return v;
    endfunction

    // Only the active phase's flags matter; a fail outranks a done in the same cycle.
    assign sel_s      = onehot_f(idx_q);
    assign fail_act_s = |(phase_fail & sel_s);
    assign done_act_s = |(phase_done & sel_s);
    assign timeout_s  = TMO_EN && (timer_q == TMO_LAST);
    assign fail_evt_s = fail_act_s || timeout_s;
    assign att_dec_s  = (att_q == 4'd0) ? 4'd0 : (att_q - 4'd1);

    // Next-state logic for the sequencer and its counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        att_d   = att_q;
        timer_d = timer_q;
        lock_d  = lock_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                timer_d = 16'd0;
            end
            S_RUN: begin
                timer_d = (timer_q == 16'hFFFF) ? timer_q : (timer_q + 16'd1);
                if (fail_evt_s) begin
                    att_d = att_dec_s;
                    if (att_dec_s == 4'd0) begin
                        state_d = S_ALARM;
                    end else begin
                        state_d = S_LOCKOUT;
                        lock_d  = LOCK_INIT;
                        idx_d   = '0;
                    end
                end else if (done_act_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_OPEN;
                    end else begin
                        state_d = S_CLEAR;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LOCKOUT: begin
                // Entered with LOCKOUT_CYCLES; leaving at 1 gives exactly that many cycles.
                if (lock_q <= 16'd1) begin
                    state_d = S_CLEAR;
                end else begin
                    lock_d = lock_q - 16'd1;
                end
            end
            S_OPEN: begin
                if (relock) begin
                    state_d = S_IDLE;
                    att_d   = ATT_INIT;
                    idx_d   = '0;
                end else begin
                    state_d = S_OPEN;
                end
            end
            S_ALARM: begin
                state_d = S_ALARM;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode from next state, so the registered outputs track the state register.
    always_comb begin
        clr_d   = '0;
        en_d    = '0;
        busy_d  = 1'b0;
        lockd_d = 1'b0;
        open_d  = 1'b0;
        alarm_d = 1'b0;
        cur_d   = 3'(idx_d);
        case (state_d)
            S_CLEAR: begin
                clr_d  = onehot_f(idx_d);
                busy_d = 1'b1;
            end
            S_RUN: begin
                en_d   = onehot_f(idx_d);
                busy_d = 1'b1;
            end
            S_LOCKOUT: begin
                busy_d  = 1'b1;
                lockd_d = 1'b1;
            end
            S_OPEN:  open_d  = 1'b1;
            S_ALARM: alarm_d = 1'b1;
            default: busy_d  = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            att_q     <= ATT_INIT;
            timer_q   <= 16'd0;
            lock_q    <= 16'd0;
            clr_q     <= '0;
            en_q      <= '0;
            cur_q     <= 3'd0;
            att_out_q <= ATT_INIT;
            busy_q    <= 1'b0;
            lockd_q   <= 1'b0;
            open_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            att_q     <= att_d;
            timer_q   <= timer_d;
            lock_q    <= lock_d;
            clr_q     <= clr_d;
            en_q      <= en_d;
            cur_q     <= cur_d;
            att_out_q <= att_d;
            busy_q    <= busy_d;
            lockd_q   <= lockd_d;
            open_q    <= open_d;
            alarm_q   <= alarm_d;
        end
    end

    assign phase_clr     = clr_q;
    assign phase_en      = en_q;
    assign cur_phase     = cur_q;
    assign attempts_left = att_out_q;
    assign busy          = busy_q;
    assign locked_out    = lockd_q;
    assign vault_open    = open_q;
    assign alarm         = alarm_q;

endmodule
